// File: rtl/bus_dest_regbank.sv
// bus_dest_regbank: write side of the 32-bit datapath bus.
// Holds every bus-readable register and captures bus_in into the one named by
// dest_sel. It also runs the MDR memory fetch, the 64-bit Z capture and the PC
// increment. Every register output comes straight from a flop.
module bus_dest_regbank #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     bus_in,
    input  logic [4:0]            dest_sel,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2*DATA_W-1:0]   z_in,
    input  logic                  z_load,
    input  logic                  pc_inc,
    input  logic                  md_read,
    output logic                  mem_rd_req,
    input  logic                  mem_rd_ack,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic [16*DATA_W-1:0]  gpr_flat,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic [DATA_W-1:0]     zhigh,
    output logic [DATA_W-1:0]     zlow,
    output logic [DATA_W-1:0]     pc,
    output logic [DATA_W-1:0]     mdr,
    output logic [DATA_W-1:0]     out_port,
    output logic                  busy,
    output logic                  dest_err
);

    // Destination codes; they match the bus multiplexer's source encoding.
    localparam logic [4:0] CODE_HI    = 5'd16;
    localparam logic [4:0] CODE_LO    = 5'd17;
    localparam logic [4:0] CODE_ZHIGH = 5'd18;
    localparam logic [4:0] CODE_ZLOW  = 5'd19;
    localparam logic [4:0] CODE_PC    = 5'd20;
    localparam logic [4:0] CODE_MDR   = 5'd21;
    localparam logic [4:0] CODE_OUT   = 5'd22;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              wr_fire;
    logic              fetch_start;
    logic              fetch_done;
    logic [DATA_W-1:0] gpr [16];

    // PC advance; wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] incr_wrap(input logic [DATA_W-1:0] v);
        return v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // A memory fetch takes priority over a bus write, and no write is accepted while a fetch is in progress.
    assign wr_ready = (state == IDLE) && !md_read;
    assign wr_fire  = wr_valid && wr_ready;
    assign busy     = (state == FETCH);

    // FSM state register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and the fetch start/finish strobes.
    always_comb begin
        state_nxt   = state;
        fetch_start = 1'b0;
        fetch_done  = 1'b0;
        case (state)
            IDLE: begin
                if (md_read) begin
                    fetch_start = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            FETCH: begin
                if (mem_rd_ack) begin
                    fetch_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory read request: set when a fetch starts and held until the ack is sampled.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)           mem_rd_req <= 1'b0;
        else if (fetch_start) mem_rd_req <= 1'b1;
        else if (fetch_done)  mem_rd_req <= 1'b0;
    end

    // General-purpose registers R0..R15. R0 is an ordinary register on the write side.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
        end else if (wr_fire && !dest_sel[4]) begin
            gpr[dest_sel[3:0]] <= bus_in;
        end
    end

    // Pack the register file into the flat output. Rn sits at [n*DATA_W +: DATA_W].
    always_comb begin
        gpr_flat = '0;
        for (int i = 0; i < 16; i++) gpr_flat[i*DATA_W +: DATA_W] = gpr[i];
    end

    // HI, LO and Out_Port load only from the bus.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            hi       <= '0;
            lo       <= '0;
            out_port <= '0;
        end else if (wr_fire) begin
            if (dest_sel == CODE_HI)  hi       <= bus_in;
            if (dest_sel == CODE_LO)  lo       <= bus_in;
            if (dest_sel == CODE_OUT) out_port <= bus_in;
        end
    end

    // Z halves. A bus write to one half wins over z_load for that half only.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            zhigh <= '0;
            zlow  <= '0;
        end else begin
            if (wr_fire && dest_sel == CODE_ZHIGH) zhigh <= bus_in;
            else if (z_load)                       zhigh <= z_in[2*DATA_W-1:DATA_W];
            if (wr_fire && dest_sel == CODE_ZLOW)  zlow  <= bus_in;
            else if (z_load)                       zlow  <= z_in[DATA_W-1:0];
        end
    end

    // PC. A bus write wins over the increment.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)                          pc <= RESET_PC;
        else if (wr_fire && dest_sel == CODE_PC) pc <= bus_in;
        else if (pc_inc)                     pc <= incr_wrap(pc);
    end

    // MDR loads from memory when a fetch completes, otherwise from the bus.
    // The two sources cannot coincide because wr_ready is low in FETCH.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)                               mdr <= '0;
        else if (fetch_done)                      mdr <= mem_rd_data;
        else if (wr_fire && dest_sel == CODE_MDR) mdr <= bus_in;
    end

    // Sticky flag for an accepted write whose code names no register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)                         dest_err <= 1'b0;
        else if (wr_fire && dest_sel > CODE_OUT) dest_err <= 1'b1;
    end

endmodule

// File: tb/tb_bus_dest_regbank.sv
// Testbench for bus_dest_regbank: directed scenarios plus random traffic.
// Each scenario is checked against a register-array reference model.
module tb_bus_dest_regbank;

    localparam int          W  = 32;
    localparam logic [31:0] RP = 32'h0000_0100;

    logic            clock = 1'b0;
    logic            clear;
    logic [W-1:0]    bus_in;
    logic [4:0]      dest_sel;
    logic            wr_valid;
    logic            wr_ready;
    logic [2*W-1:0]  z_in;
    logic            z_load;
    logic            pc_inc;
    logic            md_read;
    logic            mem_rd_req;
    logic            mem_rd_ack;
    logic [W-1:0]    mem_rd_data;
    logic [16*W-1:0] gpr_flat;
    logic [W-1:0]    hi, lo, zhigh, zlow, pc, mdr, out_port;
    logic            busy;
    logic            dest_err;

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per destination code, plus fetch and error flags.
    logic [W-1:0] m [23];
    bit           m_fetch;
    bit           m_err;

    bus_dest_regbank #(.DATA_W(W), .RESET_PC(RP)) dut (
        .clock(clock), .clear(clear), .bus_in(bus_in), .dest_sel(dest_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .z_in(z_in), .z_load(z_load),
        .pc_inc(pc_inc), .md_read(md_read), .mem_rd_req(mem_rd_req),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .gpr_flat(gpr_flat),
        .hi(hi), .lo(lo), .zhigh(zhigh), .zlow(zlow), .pc(pc), .mdr(mdr),
        .out_port(out_port), .busy(busy), .dest_err(dest_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] dut_reg(input int code);
        case (code)
            16: return hi;
            17: return lo;
            18: return zhigh;
            19: return zlow;
            20: return pc;
            21: return mdr;
            22: return out_port;
            default: return gpr_flat[code*W +: W];
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 23; i++) m[i] = '0;
        m[20]   = RP;
        m_fetch = 0;
        m_err   = 0;
    endtask

    // Apply one clock edge of the model. Inputs are stable at this point.
    task automatic model_step();
        bit accept;
        logic [W-1:0] n [23];
        accept = wr_valid && !m_fetch && !md_read;
        for (int i = 0; i < 23; i++) n[i] = m[i];
        if (z_load) begin
            n[18] = z_in[63:32];
            n[19] = z_in[31:0];
        end
        if (pc_inc) n[20] = m[20] + 32'd1;
        if (m_fetch) begin
            if (mem_rd_ack) begin
                n[21]   = mem_rd_data;
                m_fetch = 0;
            end
        end else if (md_read) begin
            m_fetch = 1;
        end
        if (accept) begin
            if (dest_sel < 5'd23) n[dest_sel] = bus_in;
            else                  m_err = 1;
        end
        for (int i = 0; i < 23; i++) m[i] = n[i];
    endtask

    task automatic check_all();
        for (int i = 0; i < 23; i++) chk($sformatf("reg%0d", i), 64'(dut_reg(i)), 64'(m[i]));
        chk("mem_rd_req", 64'(mem_rd_req), 64'(m_fetch));
        chk("busy", 64'(busy), 64'(m_fetch));
        chk("dest_err", 64'(dest_err), 64'(m_err));
    endtask

    task automatic idle_inputs();
        bus_in = '0; dest_sel = '0; wr_valid = 0; z_in = '0; z_load = 0;
        pc_inc = 0; md_read = 0; mem_rd_ack = 0; mem_rd_data = '0;
    endtask

    // Called just after a falling edge, once the inputs have been driven.
    task automatic tick();
        #1 chk("wr_ready", 64'(wr_ready), 64'(!m_fetch && !md_read));
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    int req_cycles;

    initial begin
        clear = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        clear = 1'b1;

        // Write every destination code in turn.
        for (int n = 0; n < 23; n++) begin
            wr_valid = 1; dest_sel = 5'(n); bus_in = 32'hA5A5_0001 + n;
            tick();
        end
        idle_inputs();
        tick();

        // Fetch with the ack held off for three cycles.
        req_cycles = 0;
        md_read = 1; tick(); req_cycles += int'(mem_rd_req);
        md_read = 0;
        repeat (3) begin tick(); req_cycles += int'(mem_rd_req); end
        mem_rd_ack = 1; mem_rd_data = 32'hDEAD_BEEF; tick(); req_cycles += int'(mem_rd_req);
        chk("req_cycles", 64'(req_cycles), 64'd4);
        chk("mdr_fetch", 64'(mdr), 64'hDEAD_BEEF);
        idle_inputs();

        // md_read and a bus write in the same cycle: the fetch wins.
        md_read = 1; wr_valid = 1; dest_sel = 5'd5; bus_in = 32'h5555_5555;
        tick();
        chk("r5_kept", 64'(gpr_flat[5*W +: W]), 64'(32'hA5A5_0006));
        idle_inputs();
        mem_rd_ack = 1; mem_rd_data = 32'h0BAD_F00D; tick();
        idle_inputs();

        // z_load together with a bus write to Zlow.
        z_load = 1; z_in = 64'h1111_2222_3333_4444;
        wr_valid = 1; dest_sel = 5'd19; bus_in = 32'h9;
        tick();
        chk("zhigh_mix", 64'(zhigh), 64'h1111_2222);
        chk("zlow_mix", 64'(zlow), 64'h9);
        idle_inputs();

        // PC wrap, then a bus write that overrides the increment.
        wr_valid = 1; dest_sel = 5'd20; bus_in = 32'hFFFF_FFFF; tick();
        idle_inputs(); pc_inc = 1; tick();
        chk("pc_wrap", 64'(pc), 64'h0);
        wr_valid = 1; dest_sel = 5'd20; bus_in = 32'h40; tick();
        chk("pc_bus_wins", 64'(pc), 64'h40);
        idle_inputs();

        // Invalid code: no register changes and the error flag sticks.
        wr_valid = 1; dest_sel = 5'd27; bus_in = 32'hFFFF_0000; tick();
        chk("dest_err_set", 64'(dest_err), 64'd1);
        idle_inputs(); repeat (3) tick();
        chk("dest_err_sticky", 64'(dest_err), 64'd1);

        // Asynchronous clear in the middle of a fetch.
        md_read = 1; tick();
        idle_inputs();
        #2 clear = 1'b0;
        #1;
        chk("rst_req", 64'(mem_rd_req), 64'd0);
        chk("rst_pc", 64'(pc), 64'(RP));
        chk("rst_err", 64'(dest_err), 64'd0);
        model_reset();
        @(negedge clock);
        check_all();
        clear = 1'b1;

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            wr_valid    = ($urandom_range(0, 1) == 1);
            dest_sel    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(23, 31))
                                                      : 5'($urandom_range(0, 22));
            bus_in      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            z_in        = {$urandom, $urandom};
            z_load      = ($urandom_range(0, 3) == 0);
            pc_inc      = ($urandom_range(0, 3) == 0);
            md_read     = ($urandom_range(0, 7) == 0);
            mem_rd_ack  = ($urandom_range(0, 2) == 0);
            mem_rd_data = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
